rs_issue_scheduler: RTL and testbench

- 16-entry reservation-station scheduler between dispatch and the three FUs: ALU0 (fu=0), ALU1 (fu=1), MEM (fu=2).
- Accepts up to 2 dispatched instructions per cycle and tracks operand readiness via writeback tag broadcasts.
- Each cycle, selects the oldest ready entry for each FU, subject to an FU-ready handshake.
- Holds only scheduling state. Operand/instruction payload lives in the RS payload array, indexed by the issued entry number.

---
 rtl/rs_issue_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: tracks operand readiness for 16 entries and picks
// the oldest ready entry (modular ROB age) for each of ALU0, ALU1 and MEM every cycle.
module rs_issue_scheduler #(
   parameter int unsigned NUM_ENTRIES = 16,
   parameter int unsigned IDX_W       = 4,
   parameter int unsigned TAG_W       = 6,
   parameter int unsigned ROB_W       = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_flush,
   input  logic [ROB_W-1:0] i_rob_head,
   input  logic [1:0]       i_disp_valid,
   input  logic [1:0]       i_disp_fu_a,
   input  logic [1:0]       i_disp_fu_b,
   input  logic [ROB_W-1:0] i_disp_rob_a,
   input  logic [ROB_W-1:0] i_disp_rob_b,
   input  logic [TAG_W-1:0] i_disp_src1_tag_a,
   input  logic [TAG_W-1:0] i_disp_src2_tag_a,
   input  logic [TAG_W-1:0] i_disp_src1_tag_b,
   input  logic [TAG_W-1:0] i_disp_src2_tag_b,
   input  logic             i_disp_src1_rdy_a,
   input  logic             i_disp_src2_rdy_a,
   input  logic             i_disp_src1_rdy_b,
   input  logic             i_disp_src2_rdy_b,
   output logic             o_disp_ready,
   output logic [IDX_W-1:0] o_disp_idx_a,
   output logic [IDX_W-1:0] o_disp_idx_b,
   input  logic [1:0]       i_wb_valid,
   input  logic [TAG_W-1:0] i_wb_tag0,
   input  logic [TAG_W-1:0] i_wb_tag1,
   input  logic [2:0]       i_fu_ready,
   output logic [2:0]       o_issue_valid,
   output logic [IDX_W-1:0] o_issue_idx0,
   output logic [IDX_W-1:0] o_issue_idx1,
   output logic [IDX_W-1:0] o_issue_idx2,
   output logic [ROB_W-1:0] o_issue_rob0,
   output logic [ROB_W-1:0] o_issue_rob1,
   output logic [ROB_W-1:0] o_issue_rob2,
   output logic [IDX_W:0]   o_free_count
);

   localparam int unsigned NUM_FU = 3;

   logic [NUM_ENTRIES-1:0] r_valid;
   logic [NUM_ENTRIES-1:0] r_src1_rdy;
   logic [NUM_ENTRIES-1:0] r_src2_rdy;
   logic [1:0]             r_fu       [NUM_ENTRIES];
   logic [ROB_W-1:0]       r_rob      [NUM_ENTRIES];
   logic [TAG_W-1:0]       r_src1_tag [NUM_ENTRIES];
   logic [TAG_W-1:0]       r_src2_tag [NUM_ENTRIES];
   logic [IDX_W:0]         r_free_count;

   logic [IDX_W-1:0]  w_idx_a;
   logic [IDX_W-1:0]  w_idx_b;
   logic              w_found_a;
   logic              w_found_b;
   logic              w_disp_ready;
   logic              w_wr_a;
   logic              w_wr_b;
   logic [ROB_W-1:0]  w_age     [NUM_ENTRIES];
   logic [NUM_FU-1:0] w_sel_found;
   logic [IDX_W-1:0]  w_sel_idx [NUM_FU];
   logic [ROB_W-1:0]  w_sel_age [NUM_FU];
   logic [NUM_FU-1:0] w_issue_valid;
   logic [IDX_W:0]    w_n_disp;
   logic [IDX_W:0]    w_n_issue;

   function automatic logic f_wb_hit(input logic [1:0]       wb_valid,
                                     input logic [TAG_W-1:0] tag0,
                                     input logic [TAG_W-1:0] tag1,
                                     input logic [TAG_W-1:0] tag);
      return (wb_valid[0] && (tag0 == tag)) || (wb_valid[1] && (tag1 == tag));
   endfunction

   // Two lowest free slots, from registered state only (issued entries still look busy).
   always_comb begin
      w_idx_a   = '0;
      w_idx_b   = '0;
      w_found_a = 1'b0;
      w_found_b = 1'b0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         if (!r_valid[i]) begin
            if (!w_found_a) begin
               w_idx_a   = IDX_W'(i);
               w_found_a = 1'b1;
            end else if (!w_found_b) begin
               w_idx_b   = IDX_W'(i);
               w_found_b = 1'b1;
            end
         end
      end
   end

   assign w_disp_ready = (r_free_count >= (IDX_W+1)'(2));
   assign w_wr_a       = i_disp_valid[0] && w_disp_ready && !i_flush;
   assign w_wr_b       = i_disp_valid[1] && w_disp_ready && !i_flush;

   always_comb begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         w_age[i] = r_rob[i] - i_rob_head;
      end
   end

   // Oldest-first select per FU; modular age makes ROB wrap-around transparent.
   always_comb begin
      for (int f = 0; f < int'(NUM_FU); f++) begin
         w_sel_found[f] = 1'b0;
         w_sel_idx[f]   = '0;
         w_sel_age[f]   = '0;
         for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            if (r_valid[i] && r_src1_rdy[i] && r_src2_rdy[i] && (r_fu[i] == 2'(f)) &&
                i_fu_ready[f] && (!w_sel_found[f] || (w_age[i] < w_sel_age[f]))) begin
               w_sel_found[f] = 1'b1;
               w_sel_idx[f]   = IDX_W'(i);
               w_sel_age[f]   = w_age[i];
            end
         end
      end
   end

   assign w_issue_valid = w_sel_found & {NUM_FU{~i_flush}};

   always_comb begin
      o_issue_idx0 = w_issue_valid[0] ? w_sel_idx[0] : '0;
      o_issue_idx1 = w_issue_valid[1] ? w_sel_idx[1] : '0;
      o_issue_idx2 = w_issue_valid[2] ? w_sel_idx[2] : '0;
      o_issue_rob0 = w_issue_valid[0] ? r_rob[w_sel_idx[0]] : '0;
      o_issue_rob1 = w_issue_valid[1] ? r_rob[w_sel_idx[1]] : '0;
      o_issue_rob2 = w_issue_valid[2] ? r_rob[w_sel_idx[2]] : '0;
   end

   assign w_n_disp  = (IDX_W+1)'(w_wr_a) + (IDX_W+1)'(w_wr_b);
   assign w_n_issue = (IDX_W+1)'(w_issue_valid[0]) + (IDX_W+1)'(w_issue_valid[1]) +
                      (IDX_W+1)'(w_issue_valid[2]);

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_valid      <= '0;
         r_src1_rdy   <= '0;
         r_src2_rdy   <= '0;
         r_free_count <= (IDX_W+1)'(NUM_ENTRIES);
      end else begin
         for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            if (r_valid[i] && f_wb_hit(i_wb_valid, i_wb_tag0, i_wb_tag1, r_src1_tag[i])) begin
               r_src1_rdy[i] <= 1'b1;
            end
            if (r_valid[i] && f_wb_hit(i_wb_valid, i_wb_tag0, i_wb_tag1, r_src2_tag[i])) begin
               r_src2_rdy[i] <= 1'b1;
            end
         end
         for (int f = 0; f < int'(NUM_FU); f++) begin
            if (w_issue_valid[f]) begin
               r_valid[w_sel_idx[f]] <= 1'b0;
            end
         end
         // Written entries capture a same-cycle broadcast so no wakeup is lost.
         if (w_wr_a) begin
            r_valid[w_idx_a]    <= 1'b1;
            r_fu[w_idx_a]       <= i_disp_fu_a;
            r_rob[w_idx_a]      <= i_disp_rob_a;
            r_src1_tag[w_idx_a] <= i_disp_src1_tag_a;
            r_src2_tag[w_idx_a] <= i_disp_src2_tag_a;
            r_src1_rdy[w_idx_a] <= i_disp_src1_rdy_a ||
                                   f_wb_hit(i_wb_valid, i_wb_tag0, i_wb_tag1, i_disp_src1_tag_a);
            r_src2_rdy[w_idx_a] <= i_disp_src2_rdy_a ||
                                   f_wb_hit(i_wb_valid, i_wb_tag0, i_wb_tag1, i_disp_src2_tag_a);
         end
         if (w_wr_b) begin
            r_valid[w_idx_b]    <= 1'b1;
            r_fu[w_idx_b]       <= i_disp_fu_b;
            r_rob[w_idx_b]      <= i_disp_rob_b;
            r_src1_tag[w_idx_b] <= i_disp_src1_tag_b;
            r_src2_tag[w_idx_b] <= i_disp_src2_tag_b;
            r_src1_rdy[w_idx_b] <= i_disp_src1_rdy_b ||
                                   f_wb_hit(i_wb_valid, i_wb_tag0, i_wb_tag1, i_disp_src1_tag_b);
            r_src2_rdy[w_idx_b] <= i_disp_src2_rdy_b ||
                                   f_wb_hit(i_wb_valid, i_wb_tag0, i_wb_tag1, i_disp_src2_tag_b);
         end
         r_free_count <= r_free_count - w_n_disp + w_n_issue;
      end
   end

   // fu=3 would sit in the station forever; dispatch must never send it.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         assert (!(w_wr_a && (i_disp_fu_a == 2'd3)));
         assert (!(w_wr_b && (i_disp_fu_b == 2'd3)));
      end
   end

   assign o_disp_ready  = w_disp_ready;
   assign o_disp_idx_a  = w_idx_a;
   assign o_disp_idx_b  = w_idx_b;
   assign o_issue_valid = w_issue_valid;
   assign o_free_count  = r_free_count;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler: directed scenarios plus a per-FU ROB scoreboard.
module tb_rs_issue_scheduler;

   logic       clk;
   logic       reset;
   logic       flush;
   logic [3:0] rob_head;
   logic [1:0] disp_valid;
   logic [1:0] disp_fu_a, disp_fu_b;
   logic [3:0] disp_rob_a, disp_rob_b;
   logic [5:0] s1_tag_a, s2_tag_a, s1_tag_b, s2_tag_b;
   logic       s1_rdy_a, s2_rdy_a, s1_rdy_b, s2_rdy_b;
   logic       disp_ready;
   logic [3:0] disp_idx_a, disp_idx_b;
   logic [1:0] wb_valid;
   logic [5:0] wb_tag0, wb_tag1;
   logic [2:0] fu_ready;
   logic [2:0] issue_valid;
   logic [3:0] issue_idx0, issue_idx1, issue_idx2;
   logic [3:0] issue_rob0, issue_rob1, issue_rob2;
   logic [4:0] free_count;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 0;
   int q0[$];
   int q1[$];
   int q2[$];

   rs_issue_scheduler dut (
      .i_clk             (clk),
      .i_reset           (reset),
      .i_flush           (flush),
      .i_rob_head        (rob_head),
      .i_disp_valid      (disp_valid),
      .i_disp_fu_a       (disp_fu_a),
      .i_disp_fu_b       (disp_fu_b),
      .i_disp_rob_a      (disp_rob_a),
      .i_disp_rob_b      (disp_rob_b),
      .i_disp_src1_tag_a (s1_tag_a),
      .i_disp_src2_tag_a (s2_tag_a),
      .i_disp_src1_tag_b (s1_tag_b),
      .i_disp_src2_tag_b (s2_tag_b),
      .i_disp_src1_rdy_a (s1_rdy_a),
      .i_disp_src2_rdy_a (s2_rdy_a),
      .i_disp_src1_rdy_b (s1_rdy_b),
      .i_disp_src2_rdy_b (s2_rdy_b),
      .o_disp_ready      (disp_ready),
      .o_disp_idx_a      (disp_idx_a),
      .o_disp_idx_b      (disp_idx_b),
      .i_wb_valid        (wb_valid),
      .i_wb_tag0         (wb_tag0),
      .i_wb_tag1         (wb_tag1),
      .i_fu_ready        (fu_ready),
      .o_issue_valid     (issue_valid),
      .o_issue_idx0      (issue_idx0),
      .o_issue_idx1      (issue_idx1),
      .o_issue_idx2      (issue_idx2),
      .o_issue_rob0      (issue_rob0),
      .o_issue_rob1      (issue_rob1),
      .o_issue_rob2      (issue_rob2),
      .o_free_count      (free_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      flush = 0; rob_head = 0; disp_valid = 0; wb_valid = 0; fu_ready = 3'b111;
      disp_fu_a = 0; disp_fu_b = 0; disp_rob_a = 0; disp_rob_b = 0;
      s1_tag_a = 0; s2_tag_a = 0; s1_tag_b = 0; s2_tag_b = 0;
      s1_rdy_a = 1; s2_rdy_a = 1; s1_rdy_b = 1; s2_rdy_b = 1;
      wb_tag0 = 0; wb_tag1 = 0;
   endtask

   // Scoreboard: every issued ROB must be the next expected one for that FU.
   task automatic monitor;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            for (int f = 0; f < 3; f++) begin
               logic       v;
               logic [3:0] idx;
               logic [3:0] rob;
               int         sz;
               int         e;
               case (f)
                  0:       begin v = issue_valid[0]; idx = issue_idx0; rob = issue_rob0; sz = q0.size(); end
                  1:       begin v = issue_valid[1]; idx = issue_idx1; rob = issue_rob1; sz = q1.size(); end
                  default: begin v = issue_valid[2]; idx = issue_idx2; rob = issue_rob2; sz = q2.size(); end
               endcase
               checks++;
               if (v === 1'b1) begin
                  if (sz == 0) begin
                     failures++;
                     $display("FAIL sb_unexpected fu=%0d got rob=%0d required no issue", f, rob);
                  end else begin
                     case (f)
                        0:       e = q0.pop_front();
                        1:       e = q1.pop_front();
                        default: e = q2.pop_front();
                     endcase
                     if (rob !== 4'(e)) begin
                        failures++;
                        $display("FAIL sb_order fu=%0d got rob=%0d required rob=%0d", f, rob, e);
                     end
                  end
               end else if (v !== 1'b0 || idx !== 4'd0 || rob !== 4'd0) begin
                  failures++;
                  $display("FAIL idle_zero fu=%0d got v=%b idx=%0d rob=%0d required 0/0/0",
                           f, v, idx, rob);
               end
            end
         end
      end
   endtask

   task automatic test_reset;
      clear_inputs();
      reset = 1;
      tick();
      tick();
      reset = 0;
      @(negedge clk);
      checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL rst_disp_ready got %b required 1", disp_ready); end
      checks++; if (free_count !== 5'd16) begin failures++; $display("FAIL rst_free got %0d required 16", free_count); end
      checks++; if (disp_idx_a !== 4'd0) begin failures++; $display("FAIL rst_idx_a got %0d required 0", disp_idx_a); end
      checks++; if (disp_idx_b !== 4'd1) begin failures++; $display("FAIL rst_idx_b got %0d required 1", disp_idx_b); end
      checks++; if (issue_valid !== 3'b000) begin failures++; $display("FAIL rst_issue got %b required 000", issue_valid); end
      mon_en = 1;
      tick();
   endtask

   task automatic test_dual_dispatch;
      clear_inputs();
      disp_valid = 2'b11;
      disp_fu_a = 0; disp_rob_a = 3;
      disp_fu_b = 2; disp_rob_b = 4;
      q0.push_back(3);
      q2.push_back(4);
      @(negedge clk);
      checks++; if (disp_idx_a !== 4'd0) begin failures++; $display("FAIL dd_idx_a got %0d required 0", disp_idx_a); end
      checks++; if (disp_idx_b !== 4'd1) begin failures++; $display("FAIL dd_idx_b got %0d required 1", disp_idx_b); end
      checks++; if (issue_valid !== 3'b000) begin failures++; $display("FAIL dd_no_bypass_issue got %b required 000", issue_valid); end
      tick();
      disp_valid = 0;
      @(negedge clk);
      checks++; if (issue_valid !== 3'b101) begin failures++; $display("FAIL dd_issue got %b required 101", issue_valid); end
      checks++; if (issue_idx0 !== 4'd0) begin failures++; $display("FAIL dd_idx0 got %0d required 0", issue_idx0); end
      checks++; if (issue_idx2 !== 4'd1) begin failures++; $display("FAIL dd_idx2 got %0d required 1", issue_idx2); end
      checks++; if (free_count !== 5'd14) begin failures++; $display("FAIL dd_free_mid got %0d required 14", free_count); end
      tick();
      @(negedge clk);
      checks++; if (free_count !== 5'd16) begin failures++; $display("FAIL dd_free_end got %0d required 16", free_count); end
      tick();
   endtask

   task automatic test_wakeup;
      clear_inputs();
      disp_valid = 2'b01;
      disp_fu_a = 0; disp_rob_a = 5;
      s1_tag_a = 12; s1_rdy_a = 0; s2_tag_a = 7;
      q0.push_back(5);
      @(negedge clk);
      tick();
      disp_valid = 0;
      wb_valid = 2'b01; wb_tag0 = 12;
      @(negedge clk);
      checks++; if (issue_valid[0] !== 1'b0) begin failures++; $display("FAIL wk_same_cycle got %b required 0", issue_valid[0]); end
      tick();
      wb_valid = 0;
      @(negedge clk);
      checks++; if (issue_valid[0] !== 1'b1) begin failures++; $display("FAIL wk_issue got %b required 1", issue_valid[0]); end
      checks++; if (issue_idx0 !== 4'd0) begin failures++; $display("FAIL wk_idx0 got %0d required 0", issue_idx0); end
      tick();
   endtask

   task automatic test_wrap;
      clear_inputs();
      rob_head = 14;
      disp_valid = 2'b11;
      disp_fu_a = 1; disp_rob_a = 1;
      disp_fu_b = 1; disp_rob_b = 15;
      q1.push_back(15);
      q1.push_back(1);
      @(negedge clk);
      tick();
      disp_valid = 0;
      @(negedge clk);
      checks++; if (issue_valid !== 3'b010) begin failures++; $display("FAIL wr_first_v got %b required 010", issue_valid); end
      checks++; if (issue_idx1 !== 4'd1) begin failures++; $display("FAIL wr_first_idx got %0d required 1", issue_idx1); end
      tick();
      @(negedge clk);
      checks++; if (issue_valid !== 3'b010) begin failures++; $display("FAIL wr_second_v got %b required 010", issue_valid); end
      checks++; if (issue_idx1 !== 4'd0) begin failures++; $display("FAIL wr_second_idx got %0d required 0", issue_idx1); end
      tick();
      @(negedge clk);
      checks++; if (free_count !== 5'd16) begin failures++; $display("FAIL wr_free got %0d required 16", free_count); end
      tick();
   endtask

   task automatic test_full;
      bit done;
      clear_inputs();
      for (int k = 0; k < 8; k++) begin
         disp_valid = (k < 7) ? 2'b11 : 2'b01;
         disp_fu_a = 0; disp_rob_a = 4'(2 * k);
         disp_fu_b = 0; disp_rob_b = 4'(2 * k + 1);
         s1_tag_a = 40; s1_rdy_a = 0;
         s1_tag_b = 40; s1_rdy_b = 0;
         @(negedge clk);
         if (k == 7) begin
            checks++; if (free_count !== 5'd2) begin failures++; $display("FAIL fl_free_two got %0d required 2", free_count); end
            checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL fl_ready_two got %b required 1", disp_ready); end
         end
         tick();
      end
      clear_inputs();
      @(negedge clk);
      checks++; if (disp_ready !== 1'b0) begin failures++; $display("FAIL fl_ready_full got %b required 0", disp_ready); end
      checks++; if (free_count !== 5'd1) begin failures++; $display("FAIL fl_free_full got %0d required 1", free_count); end
      tick();
      disp_valid = 2'b11;
      disp_fu_a = 1; disp_rob_a = 15;
      disp_fu_b = 1; disp_rob_b = 15;
      @(negedge clk);
      tick();
      disp_valid = 0;
      @(negedge clk);
      checks++; if (free_count !== 5'd1) begin failures++; $display("FAIL fl_drop got %0d required 1", free_count); end
      checks++; if (issue_valid !== 3'b000) begin failures++; $display("FAIL fl_drop_issue got %b required 000", issue_valid); end
      tick();
      for (int k = 0; k < 15; k++) q0.push_back(k);
      wb_valid = 2'b01; wb_tag0 = 40;
      @(negedge clk);
      checks++; if (issue_valid !== 3'b000) begin failures++; $display("FAIL fl_wake_cycle got %b required 000", issue_valid); end
      tick();
      wb_valid = 0;
      done = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (free_count == 5'd16) done = 1;
         else tick();
      end
      checks++; if (!done) begin failures++; $display("FAIL fl_drain_timeout got free=%0d required 16", free_count); end
      tick();
   endtask

   task automatic test_fu_stall;
      clear_inputs();
      fu_ready = 3'b011;
      disp_valid = 2'b01;
      disp_fu_a = 2; disp_rob_a = 6;
      q2.push_back(6);
      @(negedge clk);
      tick();
      disp_valid = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (issue_valid[2] !== 1'b0) begin failures++; $display("FAIL st_held cyc=%0d got %b required 0", k, issue_valid[2]); end
         tick();
      end
      fu_ready = 3'b111;
      @(negedge clk);
      checks++; if (issue_valid[2] !== 1'b1) begin failures++; $display("FAIL st_release got %b required 1", issue_valid[2]); end
      checks++; if (issue_idx2 !== 4'd0) begin failures++; $display("FAIL st_idx2 got %0d required 0", issue_idx2); end
      tick();
   endtask

   task automatic test_back_to_back;
      clear_inputs();
      disp_valid = 2'b11;
      disp_fu_a = 0; disp_rob_a = 2; s1_tag_a = 10; s1_rdy_a = 0; s2_tag_a = 11; s2_rdy_a = 0;
      disp_fu_b = 1; disp_rob_b = 3; s1_tag_b = 11; s1_rdy_b = 0;
      @(negedge clk);
      tick();
      clear_inputs();
      disp_valid = 2'b01;
      disp_fu_a = 2; disp_rob_a = 4; s1_tag_a = 10; s1_rdy_a = 0;
      wb_valid = 2'b11; wb_tag0 = 10; wb_tag1 = 11;
      q0.push_back(2);
      q1.push_back(3);
      q2.push_back(4);
      @(negedge clk);
      checks++; if (issue_valid !== 3'b000) begin failures++; $display("FAIL bb_wake_cycle got %b required 000", issue_valid); end
      checks++; if (disp_idx_a !== 4'd2) begin failures++; $display("FAIL bb_idx_a got %0d required 2", disp_idx_a); end
      tick();
      clear_inputs();
      @(negedge clk);
      checks++; if (issue_valid !== 3'b111) begin failures++; $display("FAIL bb_all got %b required 111", issue_valid); end
      checks++; if (issue_idx2 !== 4'd2) begin failures++; $display("FAIL bb_idx2 got %0d required 2", issue_idx2); end
      tick();
      @(negedge clk);
      checks++; if (free_count !== 5'd16) begin failures++; $display("FAIL bb_free got %0d required 16", free_count); end
      tick();
   endtask

   task automatic test_flush;
      clear_inputs();
      fu_ready = 3'b000;
      for (int k = 0; k < 4; k++) begin
         disp_valid = 2'b11;
         disp_fu_a = 0; disp_rob_a = 4'(2 * k);
         disp_fu_b = 0; disp_rob_b = 4'(2 * k + 1);
         @(negedge clk);
         tick();
      end
      flush = 1;
      fu_ready = 3'b111;
      disp_valid = 2'b11;
      disp_fu_a = 1; disp_rob_a = 8;
      disp_fu_b = 1; disp_rob_b = 9;
      @(negedge clk);
      checks++; if (free_count !== 5'd8) begin failures++; $display("FAIL fx_free_pre got %0d required 8", free_count); end
      checks++; if (issue_valid !== 3'b000) begin failures++; $display("FAIL fx_issue_flush got %b required 000", issue_valid); end
      tick();
      clear_inputs();
      @(negedge clk);
      checks++; if (free_count !== 5'd16) begin failures++; $display("FAIL fx_free_post got %0d required 16", free_count); end
      checks++; if (issue_valid !== 3'b000) begin failures++; $display("FAIL fx_issue_post got %b required 000", issue_valid); end
      checks++; if (disp_idx_a !== 4'd0) begin failures++; $display("FAIL fx_idx_a got %0d required 0", disp_idx_a); end
      checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL fx_ready got %b required 1", disp_ready); end
      tick();
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_dual_dispatch();
      test_wakeup();
      test_wrap();
      test_full();
      test_fu_stall();
      test_back_to_back();
      test_flush();
      repeat (3) tick();
      checks++; if (q0.size() != 0) begin failures++; $display("FAIL sb_left_fu0 got %0d pending required 0", q0.size()); end
      checks++; if (q1.size() != 0) begin failures++; $display("FAIL sb_left_fu1 got %0d pending required 0", q1.size()); end
      checks++; if (q2.size() != 0) begin failures++; $display("FAIL sb_left_fu2 got %0d pending required 0", q2.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
